clk_div_prog: RTL
=================

# clk_div_prog

Programmable, parametrised clock divider that generates a divided clock-enable-style square wave from the system clock. Successor to the fixed-ratio divider: divide ratio is run-time loadable (even and odd), changes are applied glitch-free at period boundaries, and the output can be paused. Sits beside the system clock as the source of slow strobes and divided clocks for downstream logic. All logic is in the single `clk` domain, with no negedge or combinational clock paths.

## Interface
- `CNT_W`, 8: width of divide ratio and phase counter; max ratio 2^CNT_W-1.
- `DEFAULT_DIV`, 4: ratio in effect after reset; must be in [2, 2^CNT_W-1].
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: one clock; reset is synchronous and active-low (`rst`=0 resets on the next `clk` rising edge).
- `en` input 1: 1 = divider runs; 0 = freeze.
- `load` input 1: single-cycle strobe; captures `div` as the pending ratio.
- `div` input CNT_W: requested divide ratio N, sampled when `load`=1.
- `clk_out` output 1: registered divided output, period N cycles.
- `tick` output 1: registered one-cycle pulse on the cycle `clk_out` rises (period start).
- `phase` output CNT_W: current position in period, 0..N-1.

## Operation
- State:
  - `n_act`: active ratio.
  - `pend`/`pend_v`: pending ratio and its valid flag.
  - `phase` counter.
  - `clk_out` and `tick` registers.
- Reset (`rst`=0 at edge):
  - `n_act`=DEFAULT_DIV.
  - `phase`=DEFAULT_DIV-1, so the first enabled edge starts a period.
  - `pend_v`=0 and any pending load is discarded.
  - `clk_out`=0, `tick`=0.
- Enabled edge (`en`=1, `rst`=1):
  - If `phase`==`n_act`-1, this is a boundary:
    - `phase`<=0.
    - `n_act`<=(`pend_v` ? `pend` : `n_act`), and `pend_v`<=0.
    - `clk_out`<=1, `tick`<=1.
  - Otherwise `phase`<=`phase`+1, `tick`<=0, and `clk_out`<=(`phase`+1 < ceil(`n_act`/2)).
- Duty cycle: `clk_out` is high for ceil(N/2) cycles and low for floor(N/2). Even N gives exactly 50%; odd N is high one cycle longer.
- Disabled edge (`en`=0):
  - `phase`, `clk_out`, and `n_act` hold.
  - `tick`<=0.
  - Loads are still captured.
- Load rules:
  - `load`=1 sets `pend`<=sat(`div`) and `pend_v`<=1, where sat() maps 0 and 1 to 2.
  - If several loads occur before a boundary, the last one wins.
  - A load on the same edge as a boundary does not affect that boundary; it applies at the next one.
- Ratio change is glitch-free:
  - The current period always completes with the old `n_act`.
  - The new period starts high with the new ratio.
  - No runt pulses.
- Reset has priority over `en` and `load` in any state.

## Timing
- Output latency:
  - Outputs are registered.
  - After `rst` goes 1 with `en`=1, `clk_out` and `tick` go 1 at the first rising edge.
- Load latency:
  - New ratio takes effect at the first boundary strictly after the load edge.
  - Worst case N_old cycles.
- `tick`:
  - Exactly one cycle high per period while enabled.
  - Never high while `en`=0.
- `en` pause:
  - The waveform is stretched by the number of disabled cycles.
  - Phase is preserved with no skip or repeat.
- `phase` wraps N-1→0 only at a boundary and never exceeds `n_act`-1.

## Test plan
- Reset then run:
  - Stimulus: `rst`=0 for 5 cycles, then `rst`=1 with `en`=1 and defaults (CNT_W=8, DEFAULT_DIV=4).
  - During reset: `clk_out`=0, `tick`=0, `phase`=3.
  - After release: `clk_out` = 1,1,0,0 repeating; `tick` high every 4th cycle starting at the first edge; `phase` = 0,1,2,3.
- Odd ratio, mid-period load:
  - Stimulus: load `div`=5 at `phase`=1.
  - The current period finishes as 4 cycles.
  - Then `clk_out` is high 3, low 2 repeating, with `tick` period 5.
- Saturation and last-wins:
  - Load `div`=0: period becomes 2, `clk_out` toggles every cycle.
  - Load 7 then 1 before the same boundary: period 2 (1 saturates, last wins).
- Pause:
  - Stimulus: `en`=0 for 6 cycles at ratio 4, `phase`=1.
  - `clk_out` holds 1, `phase` holds 1, `tick`=0 throughout.
  - On resume, `phase`=2 next cycle and the waveform continues unchanged.
- Reset mid-operation:
  - Stimulus: load 9, then `rst`=0 before the boundary.
  - Pending load is discarded; after release the divider runs at ratio 4.
- Max ratio:
  - Stimulus: load 255.
  - `clk_out` is high 128, low 127; `phase` reaches 254 then wraps to 0 with `tick`=1.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable clock divider: run-time loadable ratio (even or odd), applied only at
// period boundaries, with a pause input and registered clk_out/tick/phase outputs.
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] phase
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_PH  = DEF_DIV - ONE;

    // Ratios below 2 cannot form a period with both a high and a low half.
    function automatic logic [CNT_W-1:0] sat_div(input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] r;
        if (d < MIN_DIV) begin
            r = MIN_DIV;
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic [CNT_W-1:0] n_act_r, pend_r, phase_r;
    logic             pend_v_r, clk_out_r, tick_r;

    logic [CNT_W-1:0] n_act_nxt_s, pend_nxt_s, phase_nxt_s;
    logic             pend_v_nxt_s, clk_out_nxt_s, tick_nxt_s;
    logic [CNT_W-1:0] phase_inc_s, half_s;
    logic             boundary_s;

    // Next-state computation for the period counter, ratio and pending load.
    always_comb begin
        n_act_nxt_s   = n_act_r;
        pend_nxt_s    = pend_r;
        pend_v_nxt_s  = pend_v_r;
        phase_nxt_s   = phase_r;
        clk_out_nxt_s = clk_out_r;
        tick_nxt_s    = 1'b0;

        phase_inc_s = phase_r + ONE;
        // ceil(n/2) without widening: floor(n/2) plus the odd bit
        half_s      = {1'b0, n_act_r[CNT_W-1:1]} + {{(CNT_W-1){1'b0}}, n_act_r[0]};
        boundary_s  = en && (phase_r == (n_act_r - ONE));

        if (en) begin
            if (boundary_s) begin
                phase_nxt_s   = {CNT_W{1'b0}};
                clk_out_nxt_s = 1'b1;
                tick_nxt_s    = 1'b1;
                if (pend_v_r) begin
                    n_act_nxt_s = pend_r;
                end else begin
                    n_act_nxt_s = n_act_r;
                end
            end else begin
                phase_nxt_s   = phase_inc_s;
                clk_out_nxt_s = (phase_inc_s < half_s);
                tick_nxt_s    = 1'b0;
            end
        end else begin
            phase_nxt_s   = phase_r;
            clk_out_nxt_s = clk_out_r;
            tick_nxt_s    = 1'b0;
        end

        // A load on a boundary edge keeps pend_v set so it applies at the next boundary.
        if (load) begin
            pend_nxt_s   = sat_div(div);
            pend_v_nxt_s = 1'b1;
        end else if (boundary_s) begin
            pend_nxt_s   = pend_r;
            pend_v_nxt_s = 1'b0;
        end else begin
            pend_nxt_s   = pend_r;
            pend_v_nxt_s = pend_v_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_act_r   <= DEF_DIV;
            pend_r    <= DEF_DIV;
            pend_v_r  <= 1'b0;
            phase_r   <= DEF_PH;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            n_act_r   <= n_act_nxt_s;
            pend_r    <= pend_nxt_s;
            pend_v_r  <= pend_v_nxt_s;
            phase_r   <= phase_nxt_s;
            clk_out_r <= clk_out_nxt_s;
            tick_r    <= tick_nxt_s;
        end
    end

    assign clk_out = clk_out_r;
    assign tick    = tick_r;
    assign phase   = phase_r;

endmodule
